// File: rtl/add_sub_pipe.sv
// Pipelined adder/subtractor, one SEG_W-bit ripple segment per stage; latency WIDTH/SEG_W cycles.
// Backpressure: the whole pipe freezes while a result waits on out_ready; in_ready mirrors the advance.
module add_sub_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = WIDTH / SEG_W;
    localparam int SKW    = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int L      = STAGES - 1;

    if (WIDTH % SEG_W != 0) begin : g_bad_cfg
        $fatal(1, "add_sub_pipe: WIDTH must be a multiple of SEG_W");
    end

    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  fwd_a  [SKW];
    logic [WIDTH-1:0]  fwd_b  [SKW];
    logic [WIDTH-1:0]  part_s [STAGES];
    logic [STAGES-1:0] part_c;
    logic              ovf_q;
    logic              zero_q;

    logic [WIDTH-1:0]  op_a [STAGES];
    logic [WIDTH-1:0]  op_b [STAGES];
    logic [WIDTH-1:0]  op_s [STAGES];
    logic [WIDTH-1:0]  nx_s [STAGES];
    logic [SEG_W:0]    seg  [STAGES];
    logic [STAGES-1:0] op_c;
    logic [STAGES-1:0] op_v;
    logic [STAGES-1:0] nx_c;
    logic              advance;
    logic              ovf_nx;

    always_comb begin
        advance = ~vld[L] | out_ready;
        op_a[0] = a;
        op_b[0] = sub ? ~b : b;
        op_s[0] = '0;
        op_c[0] = cin;
        op_v[0] = in_valid;
        // Stage k sees the skewed operands and partial sum left by stage k-1.
        for (int k = 1; k < STAGES; k++) begin
            op_a[k] = fwd_a[k-1];
            op_b[k] = fwd_b[k-1];
            op_s[k] = part_s[k-1];
            op_c[k] = part_c[k-1];
            op_v[k] = vld[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            seg[k]  = {1'b0, op_a[k][k*SEG_W +: SEG_W]}
                    + {1'b0, op_b[k][k*SEG_W +: SEG_W]}
                    + {{SEG_W{1'b0}}, op_c[k]};
            nx_s[k] = op_s[k];
            nx_s[k][k*SEG_W +: SEG_W] = seg[k][SEG_W-1:0];
            nx_c[k] = seg[k][SEG_W];
        end
        ovf_nx = (op_a[L][WIDTH-1] == op_b[L][WIDTH-1]) &
                 (nx_s[L][WIDTH-1] != op_a[L][WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld    <= '0;
            part_c <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) part_s[k] <= '0;
            for (int k = 0; k < SKW; k++) begin
                fwd_a[k] <= '0;
                fwd_b[k] <= '0;
            end
        end else if (advance) begin
            vld <= op_v;
            // Data only moves with a live beat, so idle bubbles leave the last result in place.
            for (int k = 0; k < STAGES; k++) begin
                if (op_v[k]) begin
                    part_s[k] <= nx_s[k];
                    part_c[k] <= nx_c[k];
                end
            end
            for (int k = 0; k < STAGES - 1; k++) begin
                if (op_v[k]) begin
                    fwd_a[k] <= op_a[k];
                    fwd_b[k] <= op_b[k];
                end
            end
            if (op_v[L]) begin
                ovf_q  <= ovf_nx;
                zero_q <= (nx_s[L] == '0);
            end
        end
    end

    assign in_ready  = advance;
    assign out_valid = vld[L];
    assign sum       = part_s[L];
    assign cout      = part_c[L];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Scoreboard bench for add_sub_pipe at 32/8, 16/16 and 64/4.
module tb_add_sub_pipe;

    typedef struct {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        z;
        int          t;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, overflow, zero;
    logic [31:0] a, b, sum;

    logic        p_valid, p_cin, p_sub, p_ordy;
    logic [15:0] a16, b16, s16;
    logic        r16, v16o, c16, o16, z16;
    logic [63:0] a64, b64, s64;
    logic        r64, v64o, c64, o64, z64;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t q32[$], q16[$], q64[$];
    exp_t e32, e16, e64;
    bit          held;
    logic [34:0] held_dat;

    add_sub_pipe #(.WIDTH(32), .SEG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .zero(zero));

    add_sub_pipe #(.WIDTH(16), .SEG_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(p_valid), .in_ready(r16),
        .a(a16), .b(b16), .cin(p_cin), .sub(p_sub), .out_valid(v16o), .out_ready(p_ordy),
        .sum(s16), .cout(c16), .overflow(o16), .zero(z16));

    add_sub_pipe #(.WIDTH(64), .SEG_W(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(p_valid), .in_ready(r64),
        .a(a64), .b(b64), .cin(p_cin), .sub(p_sub), .out_valid(v64o), .out_ready(p_ordy),
        .sum(s64), .cout(c64), .overflow(o64), .zero(z64));

    always @(posedge clk) cyc = cyc + 1;

    // Reference: full-width a + (sub ? ~b : b) + cin, independent of segmenting.
    function automatic exp_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                   input logic ci, input logic sb);
        logic [64:0] m, full;
        logic [63:0] xm, be;
        exp_t e;
        m    = (65'd1 << w) - 65'd1;
        xm   = x & m[63:0];
        be   = (sb ? ~y : y) & m[63:0];
        full = {1'b0, xm} + {1'b0, be} + {64'd0, ci};
        e.s  = full[63:0] & m[63:0];
        e.c  = full[w];
        e.o  = (xm[w-1] == be[w-1]) && (e.s[w-1] != xm[w-1]);
        e.z  = (e.s == 64'd0);
        e.t  = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (in_ready !== (!out_valid || out_ready)) begin
                bad++;
                $display("FAIL ready32 t=%0t in_ready=%b out_valid=%b out_ready=%b", $time, in_ready, out_valid, out_ready);
            end
            if (held) begin
                total++;
                if (out_valid !== 1'b1 || {sum, cout, overflow, zero} !== held_dat) begin
                    bad++;
                    $display("FAIL hold32 t=%0t got v=%b %h want %h", $time, out_valid, {sum, cout, overflow, zero}, held_dat);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (q32.size() == 0) begin
                    bad++;
                    $display("FAIL stray32 t=%0t sum=%h with nothing expected", $time, sum);
                end else begin
                    e32 = q32.pop_front();
                    if ({sum, cout, overflow, zero} !== {e32.s[31:0], e32.c, e32.o, e32.z}) begin
                        bad++;
                        $display("FAIL res32 got sum=%h c=%b o=%b z=%b want sum=%h c=%b o=%b z=%b",
                                 sum, cout, overflow, zero, e32.s[31:0], e32.c, e32.o, e32.z);
                    end
                    if (e32.lat) begin
                        total++;
                        if (cyc - e32.t != 4) begin
                            bad++;
                            $display("FAIL lat32 got %0d want 4", cyc - e32.t);
                        end
                    end
                end
            end
            held     = out_valid && !out_ready;
            held_dat = {sum, cout, overflow, zero};
        end else begin
            held = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (r16 !== 1'b1 || r64 !== 1'b1) begin
                bad++;
                $display("FAIL ready_p got r16=%b r64=%b want 1 1", r16, r64);
            end
            if (v16o) begin
                total++;
                if (q16.size() == 0) begin
                    bad++;
                    $display("FAIL stray16 sum=%h", s16);
                end else begin
                    e16 = q16.pop_front();
                    if ({s16, c16, o16, z16} !== {e16.s[15:0], e16.c, e16.o, e16.z}) begin
                        bad++;
                        $display("FAIL res16 got %h %b%b%b want %h %b%b%b", s16, c16, o16, z16, e16.s[15:0], e16.c, e16.o, e16.z);
                    end
                    if (e16.lat) begin
                        total++;
                        if (cyc - e16.t != 1) begin
                            bad++;
                            $display("FAIL lat16 got %0d want 1", cyc - e16.t);
                        end
                    end
                end
            end
            if (v64o) begin
                total++;
                if (q64.size() == 0) begin
                    bad++;
                    $display("FAIL stray64 sum=%h", s64);
                end else begin
                    e64 = q64.pop_front();
                    if ({s64, c64, o64, z64} !== {e64.s, e64.c, e64.o, e64.z}) begin
                        bad++;
                        $display("FAIL res64 got %h %b%b%b want %h %b%b%b", s64, c64, o64, z64, e64.s, e64.c, e64.o, e64.z);
                    end
                    if (e64.lat) begin
                        total++;
                        if (cyc - e64.t != 16) begin
                            bad++;
                            $display("FAIL lat64 got %0d want 16", cyc - e64.t);
                        end
                    end
                end
            end
        end
    end

    task automatic send32(input logic [31:0] x, input logic [31:0] y, input logic ci,
                          input logic sb, input bit lat);
        bit   acc;
        int   c;
        exp_t e;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            acc = in_ready;
            c   = cyc;
            @(posedge clk);
            if (acc) begin
                e = model(32, {32'd0, x}, {32'd0, y}, ci, sb);
                e.t = c;
                e.lat = lat;
                q32.push_back(e);
                #1;
                return;
            end
        end
        total++; bad++;
        $display("FAIL send32 beat never accepted");
    endtask

    task automatic send_p(input logic [63:0] x, input logic [63:0] y, input logic ci, input logic sb);
        bit   acc;
        int   c;
        exp_t e;
        a16 = x[15:0]; b16 = y[15:0]; a64 = x; b64 = y; p_cin = ci; p_sub = sb; p_valid = 1'b1;
        @(negedge clk);
        acc = r16 && r64;
        c   = cyc;
        @(posedge clk);
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL accept_p got r16=%b r64=%b want 1 1", r16, r64);
        end else begin
            e = model(16, x, y, ci, sb); e.t = c; e.lat = 1'b1; q16.push_back(e);
            e = model(64, x, y, ci, sb); e.t = c; e.lat = 1'b1; q64.push_back(e);
        end
        #1;
    endtask

    task automatic wait_out32();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        total++; bad++;
        $display("FAIL wait32 out_valid never rose");
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200; n++) begin
            if (q32.size() == 0 && q16.size() == 0 && q64.size() == 0) return;
            @(negedge clk);
        end
        total++; bad++;
        $display("FAIL drain left q32=%0d q16=%0d q64=%0d", q32.size(), q16.size(), q64.size());
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        p_valid = 1'b0; p_ordy = 1'b1; p_cin = 1'b0; p_sub = 1'b0; a16 = '0; b16 = '0; a64 = '0; b64 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({out_valid, v16o, v64o} !== 3'b000) begin
            bad++;
            $display("FAIL rst_valid got %b%b%b want 000", out_valid, v16o, v64o);
        end
        total++;
        if ({sum, cout, overflow, zero} !== 35'd0) begin
            bad++;
            $display("FAIL rst_outputs got sum=%h c=%b o=%b z=%b want all 0", sum, cout, overflow, zero);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_in_ready got %b want 1", in_ready);
        end
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid || v16o || v64o) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL idle_valid got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_carry();
        @(posedge clk); #1;
        send32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_out32();
        total++;
        if ({sum, cout, zero, overflow} !== {32'h0000_0000, 1'b1, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL carry32 got sum=%h c=%b z=%b o=%b want 00000000 1 1 0", sum, cout, zero, overflow);
        end
        wait_drain();
    endtask

    task automatic test_sub_ovf();
        @(posedge clk); #1;
        send32(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1);
        send32(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_out32();
        total++;
        if ({sum, cout, overflow} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL sub32 got sum=%h c=%b o=%b want fffffffe 0 0", sum, cout, overflow);
        end
        @(negedge clk);
        total++;
        if ({out_valid, sum, overflow} !== {1'b1, 32'h8000_0000, 1'b1}) begin
            bad++;
            $display("FAIL ovf32 got v=%b sum=%h o=%b want 1 80000000 1", out_valid, sum, overflow);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int stl = 0;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 8; i++) send32(i, i * 32'h0101_0101, 1'b0, 1'b0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (!in_ready && out_valid) stl++;
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        total++;
        if (stl != 3) begin
            bad++;
            $display("FAIL stall_cycles got %0d want 3", stl);
        end
        wait_drain();
    endtask

    task automatic test_midstream_reset();
        int seen;
        @(posedge clk); #1;
        for (int i = 1; i <= 5; i++) send32(32'h1111_0000 + i, 32'h10 * i, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_valid got %b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, sum} !== {1'b0, 32'd0}) begin
            bad++;
            $display("FAIL async_reset got v=%b sum=%h want 0 00000000", out_valid, sum);
        end
        q32.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL stale_beats got %0d valid cycles want 0", seen);
        end
        @(posedge clk); #1;
        send32(32'd2, 32'd3, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_out32();
        total++;
        if (sum !== 32'd5) begin
            bad++;
            $display("FAIL post_reset_sum got %h want 00000005", sum);
        end
        wait_drain();
    endtask

    task automatic test_param();
        logic [63:0] x, y;
        @(posedge clk); #1;
        send_p(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0);
        total++;
        if ({v16o, s16, c16, z16} !== {1'b1, 16'h0000, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL carry16 got v=%b sum=%h c=%b z=%b want 1 0000 1 1", v16o, s16, c16, z16);
        end
        send_p(64'h7FFF_FFFF_FFFF_7FFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        send_p(64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b1, 1'b1);
        for (int i = 0; i < 10000; i++) begin
            x = {$urandom(), $urandom()};
            y = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0: x = 64'h7FFF_FFFF_FFFF_FFFF;
                1: y = ~x;
                2: x = 64'h8000_0000_0000_8000;
                default: ;
            endcase
            send_p(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        p_valid = 1'b0;
        wait_drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_carry();
        test_sub_ovf();
        test_back_to_back();
        test_midstream_reset();
        test_param();
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
